// File: rtl/vip_gray_frame_source_if.sv
// vip_gray_frame_source_if: pixel-stream bundle carried from the gray frame source to its sink.
interface vip_gray_frame_source_if;
    logic       pe_frame_vsync;
    logic       pe_frame_href;
    logic       pe_frame_clken;
    logic [7:0] pe_img_Y;
    logic       frame_done;
    logic [7:0] frame_cnt;
    modport master (output pe_frame_vsync, pe_frame_href, pe_frame_clken, pe_img_Y, frame_done, frame_cnt);
    modport slave  (input  pe_frame_vsync, pe_frame_href, pe_frame_clken, pe_img_Y, frame_done, frame_cnt);
endinterface

// File: rtl/vip_gray_frame_source.sv
// vip_gray_frame_source: synthetic gray-ramp video frame generator with frame sync and counter.
// Define VIP_SRC_NOISE_EN to add LFSR-driven salt-and-pepper noise on active pixels.
module vip_gray_frame_source #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 2,
    parameter int V_FRONT  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    vip_gray_frame_source_if.master vo
);
    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int HW    = H_TOT > 1 ? $clog2(H_TOT) : 1;
    localparam int V_M1  = V_SYNC > V_BACK ? V_SYNC : V_BACK;
    localparam int V_M2  = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = V_M1 > V_M2 ? V_M1 : V_M2;
    localparam int LW    = V_MAX > 1 ? $clog2(V_MAX) : 1;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;
    logic [2:0]    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [LW-1:0] l_q, l_d, l_last;
    logic          vsync_q, vsync_d, href_q, href_d, done_q, done_d;
    logic [7:0]    y_q, y_d, cnt_q, cnt_d, base;
    logic          line_end, last;
`ifdef VIP_SRC_NOISE_EN
    logic [15:0]   lfsr_q, lfsr_d;
`endif
    // Outputs are computed from the next raster position so they register alongside it.
    always_comb begin
        line_end = h_q == HW'(H_TOT - 1);
        l_last   = state_q == S_VSYNC  ? LW'(V_SYNC - 1)   :
                   state_q == S_VBACK  ? LW'(V_BACK - 1)   :
                   state_q == S_ACTIVE ? LW'(V_ACTIVE - 1) : LW'(V_FRONT - 1);
        last     = line_end && l_q == l_last;
        h_d      = (state_q == S_IDLE || line_end) ? '0 : h_q + 1'b1;
        l_d      = (state_q == S_IDLE || last) ? '0 : line_end ? l_q + 1'b1 : l_q;
        state_d  = state_q == S_IDLE   ? (en ? S_VSYNC : S_IDLE) :
                   !last               ? state_q :
                   state_q == S_VSYNC  ? S_VBACK :
                   state_q == S_VBACK  ? S_ACTIVE :
                   state_q == S_ACTIVE ? S_VFRONT : (en ? S_VSYNC : S_IDLE);
        vsync_d  = state_d == S_VSYNC;
        href_d   = state_d == S_ACTIVE && h_d < HW'(H_ACTIVE);
        done_d   = state_d == S_VFRONT && h_d == HW'(H_TOT - 1) && l_d == LW'(V_FRONT - 1);
        cnt_d    = cnt_q + {7'd0, done_q};
        base     = 8'(h_d) + 8'(l_d) + cnt_d;
`ifdef VIP_SRC_NOISE_EN
        lfsr_d   = href_d ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        y_d      = !href_d ? 8'd0 : lfsr_q[15:12] == 4'hF ? {8{lfsr_q[0]}} : base;
`else
        y_d      = href_d ? base : 8'd0;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            l_q     <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            done_q  <= done_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end
`ifdef VIP_SRC_NOISE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif
    assign vo.pe_frame_vsync = vsync_q;
    assign vo.pe_frame_href  = href_q;
    assign vo.pe_frame_clken = href_q;
    assign vo.pe_img_Y       = y_q;
    assign vo.frame_done     = done_q;
    assign vo.frame_cnt      = cnt_q;
endmodule

// File: tb/tb_vip_gray_frame_source.sv
// tb_vip_gray_frame_source: directed bench on a 4x3 raster (6-cycle lines, 36-cycle frames).
module tb_vip_gray_frame_source;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    always #5 clk = ~clk;
    vip_gray_frame_source_if vo();
    vip_gray_frame_source #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_SYNC(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vo(vo)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_idle(input string tag, input logic [7:0] fc);
        check({tag, "_vsync"}, vo.pe_frame_vsync, 0);
        check({tag, "_href"}, vo.pe_frame_href, 0);
        check({tag, "_clken"}, vo.pe_frame_clken, 0);
        check({tag, "_y"}, vo.pe_img_Y, 0);
        check({tag, "_done"}, vo.frame_done, 0);
        check({tag, "_cnt"}, vo.frame_cnt, fc);
    endtask
    // Cycle c of a frame: line (c-1)/6 is vsync, vback, 3 active, vfront; h=(c-1)%6.
    task automatic run_frame(input logic [7:0] f, input int drop_at);
        for (int c = 1; c <= 36; c++) begin
            int line;
            int h;
            logic act;
            logic [7:0] py;
            @(negedge clk);
            line = (c - 1) / 6;
            h = (c - 1) % 6;
            act = line >= 2 && line <= 4 && h < 4;
            py = act ? 8'(h + line - 2 + int'(f)) : 8'd0;
`ifdef VIP_SRC_NOISE_EN
            if (act) begin
                if (lfsr_m[15:12] == 4'hF) py = {8{lfsr_m[0]}};
                lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            end
`endif
            check($sformatf("f%0d_c%0d_vsync", f, c), vo.pe_frame_vsync, line == 0);
            check($sformatf("f%0d_c%0d_href", f, c), vo.pe_frame_href, act);
            check($sformatf("f%0d_c%0d_clken", f, c), vo.pe_frame_clken, act);
            check($sformatf("f%0d_c%0d_y", f, c), vo.pe_img_Y, py);
            check($sformatf("f%0d_c%0d_done", f, c), vo.frame_done, c == 36);
            check($sformatf("f%0d_c%0d_cnt", f, c), vo.frame_cnt, f);
            if (c == drop_at) en = 1'b0;
        end
    endtask
    initial begin
        #12;
        check_idle("reset", 8'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle("idle_no_en", 8'd0);
        end
        en = 1'b1;
        run_frame(8'd0, 0);
        run_frame(8'd1, 0);
        run_frame(8'd2, 15);
        repeat (3) begin
            @(negedge clk);
            check_idle("idle_after_drop", 8'd3);
        end
        en = 1'b1;
        repeat (14) @(negedge clk);
        check("pre_rst_href", vo.pe_frame_href, 1);
        check("pre_rst_cnt", vo.frame_cnt, 3);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst", 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lfsr_m = 16'hACE1;
        for (int f = 0; f < 256; f++) run_frame(8'(f), 0);
        run_frame(8'd0, 36);
        repeat (2) begin
            @(negedge clk);
            check_idle("idle_after_wrap", 8'd1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vip_gray_frame_source.md
VIP_GRAY_FRAME_SOURCE -- requirements
Module: vip_gray_frame_source

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, active pixels per line; H_BLANK 160, blank cycles per line; V_ACTIVE 480, active lines; V_SYNC 2, vsync lines; V_BACK 2, back-porch lines; V_FRONT 2, front-porch lines.
REQ-002 clk  input  1  single system clock (50MHz); all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  generation enable, sampled only at frame boundaries.
REQ-005 pe_frame_vsync  output  1  frame sync, high during V_SYNC lines.
REQ-006 pe_frame_href  output  1  line valid, high for the H_ACTIVE cycles of each active line.
REQ-007 pe_frame_clken  output  1  pixel enable, equal to pe_frame_href.
REQ-008 pe_img_Y  output  8  gray pixel; 0 whenever pe_frame_href is low.
REQ-009 frame_done  output  1  one-cycle pulse on the last cycle of each frame.
REQ-010 frame_cnt  output  8  completed-frame counter, wraps 255->0.

Function
REQ-011 Line timing SHALL be H_ACTIVE+H_BLANK cycles for every line in every state; h counter 0..H_ACTIVE+H_BLANK-1, active when h < H_ACTIVE.
REQ-012 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, VFRONT; each non-IDLE state lasts its parameter's number of lines.
REQ-013 IDLE->VSYNC when en=1 is sampled in IDLE; VSYNC->VBACK->ACTIVE->VFRONT on line-count expiry.
REQ-014 At VFRONT expiry: to VSYNC if en=1 that cycle (back-to-back frames, no gap), else to IDLE.
REQ-015 en deasserted mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-016 All outputs SHALL be registered; first VSYNC cycle appears on the output the cycle after en is sampled high in IDLE.
REQ-017 pe_frame_href/clken SHALL be high only in ACTIVE with h < H_ACTIVE; never in VSYNC, VBACK, VFRONT, or IDLE.
REQ-018 Pixel value SHALL be (x + y + frame_cnt) mod 256, x = h within line, y = active line index 0..V_ACTIVE-1, all 8-bit truncated.
REQ-019 frame_done SHALL pulse exactly once per frame, in the final cycle of VFRONT; frame_cnt SHALL increment in the same cycle it is registered, so the new value is visible from the next cycle.
REQ-020 Counters SHALL be sized by $clog2 of their parameter maxima; no overflow for any legal parameter set (all >= 1).

Reset
REQ-021 On rst_n low (any time, including mid-line): state IDLE, h/line counters 0, all outputs 0, frame_cnt 0, LFSR to seed 16'hACE1.
REQ-022 After rst_n release, no output SHALL toggle until en=1 is sampled.

Configuration
REQ-023 Macro VIP_SRC_NOISE_EN SHALL compile in salt-and-pepper noise injection for median-filter testing.
REQ-024 With VIP_SRC_NOISE_EN: 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing once per active pixel; when lfsr[15:12]==4'hF the pixel SHALL be 8'hFF if lfsr[0]=1, else 8'h00 (rate 1/16); otherwise REQ-018 value.
REQ-025 Without VIP_SRC_NOISE_EN: no LFSR logic; pe_img_Y strictly per REQ-018.

Verification (params H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_SYNC=V_BACK=V_FRONT=1; frame = 36 cycles)
REQ-026 Reset release, en=1 held -> vsync high 6 cycles, 6 blank cycles, then href pulses of 4 high / 2 low x3, 6 blank cycles, frame_done at cycle 36, next vsync at cycle 37.
REQ-027 Frame 0 pixels -> rows 0,1,2,3 / 1,2,3,4 / 2,3,4,5; frame 1 row 0 -> 1,2,3,4; frame_cnt=1 after first frame_done.
REQ-028 en dropped during frame 0 ACTIVE -> frame 0 completes with all 12 pixels, frame_done once, then IDLE with all outputs 0.
REQ-029 rst_n pulsed low mid-href -> href, vsync, clken, pe_img_Y, frame_cnt 0 asynchronously; restart yields frame 0 values again.
REQ-030 VIP_SRC_NOISE_EN defined, 256 frames -> only values 0x00/0xFF deviate from REQ-018 and match a reference LFSR model; undefined -> zero deviations.
REQ-031 frame_cnt after 256 frame_done pulses -> wraps to 0; pixel (0,0) of next frame = 0.
